// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration-time parameter checks for the synchronous FIFO.
package sync_fifo_pkg;

    localparam string RAM_DISTRIBUTED = "distributed";
    localparam string RAM_BLOCK       = "block";

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit almost_ok(input int val, input int depth);
        return (val >= 0) && (val < depth);
    endfunction

    function automatic bit ram_type_ok(input string ram_type);
        return (ram_type == RAM_DISTRIBUTED) || (ram_type == RAM_BLOCK);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port inferred RAM: one write port, one registered read port.
module fifo_ram #(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 3,
    parameter string RAM_TYPE   = "block"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Array is left unreset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/random_state_gen.sv
// Traffic pacer: o_state alternates 0/1 with LFSR-chosen run lengths in bounded ranges.
//   state   | meaning
//   ST_ZERO | o_state low; timer counts down the remaining N0 cycles
//   ST_ONE  | o_state high; timer counts down the remaining N1 cycles
module random_state_gen #(
    parameter int unsigned STATE_0_MIN_VAL = 1,
    parameter int unsigned STATE_0_MAX_VAL = 4,
    parameter int unsigned STATE_1_MIN_VAL = 1,
    parameter int unsigned STATE_1_MAX_VAL = 4,
    parameter logic [31:0] SEED            = 32'h1
) (
    input  logic i_clk,
    input  logic i_a_rst,
    output logic o_state
);

    typedef enum logic {ST_ZERO, ST_ONE} state_t;

    if (STATE_0_MIN_VAL < 1 || STATE_1_MIN_VAL < 1 ||
        STATE_0_MAX_VAL < STATE_0_MIN_VAL || STATE_1_MAX_VAL < STATE_1_MIN_VAL) begin : g_bad_range
        $error("random_state_gen: each range needs 1 <= MIN <= MAX");
    end

    localparam logic [31:0] SPAN0      = 32'(STATE_0_MAX_VAL - STATE_0_MIN_VAL + 1);
    localparam logic [31:0] SPAN1      = 32'(STATE_1_MAX_VAL - STATE_1_MIN_VAL + 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [31:0] SEED_NZ    = (SEED == 32'd0) ? 32'h1 : SEED;
    localparam logic [31:0] INIT_TIMER = 32'(STATE_0_MIN_VAL) + (SEED_NZ % SPAN0) - 32'd1;

    state_t      state;
    state_t      state_next;
    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic [31:0] timer;
    logic [31:0] timer_load;

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'd0);

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            state <= ST_ZERO;
            lfsr  <= SEED_NZ;
            timer <= INIT_TIMER;
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next;
            timer <= (timer == 32'd0) ? timer_load : timer - 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        if (timer == 32'd0) begin
            state_next = (state == ST_ZERO) ? ST_ONE : ST_ZERO;
        end
        timer_load = (state_next == ST_ONE)
                   ? 32'(STATE_1_MIN_VAL) + (lfsr % SPAN1) - 32'd1
                   : 32'(STATE_0_MIN_VAL) + (lfsr % SPAN0) - 32'd1;
    end

    always_comb begin
        o_state = (state == ST_ONE);
    end

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with registered read data and registered full/empty/almost flags.
module sync_fifo_core
    import sync_fifo_pkg::*;
#(
    parameter int    DATA_WIDTH       = 8,
    parameter int    FIFO_DEPTH       = 8,
    parameter int    ALMOST_FULL_VAL  = 2,
    parameter int    ALMOST_EMPTY_VAL = 2,
    parameter string RAM_TYPE         = "block"
) (
    input  logic                  i_clk,
    input  logic                  i_a_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_almost_full,
    output logic                  o_full,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_almost_empty,
    output logic                  o_empty,
    output logic                  o_rd_valid
);

    localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int COUNT_WIDTH = count_width(FIFO_DEPTH);

    localparam logic [COUNT_WIDTH-1:0] DEPTH_C   = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] AF_THRESH = COUNT_WIDTH'(FIFO_DEPTH - ALMOST_FULL_VAL);
    localparam logic [COUNT_WIDTH-1:0] AE_THRESH = COUNT_WIDTH'(ALMOST_EMPTY_VAL);

    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("sync_fifo_core: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (!almost_ok(ALMOST_FULL_VAL, FIFO_DEPTH) || !almost_ok(ALMOST_EMPTY_VAL, FIFO_DEPTH)) begin : g_bad_almost
        $error("sync_fifo_core: almost thresholds must lie in [0, FIFO_DEPTH)");
    end
    if (!ram_type_ok(RAM_TYPE)) begin : g_bad_ram_type
        $error("sync_fifo_core: RAM_TYPE must be \"distributed\" or \"block\"");
    end

    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   wr_acc;
    logic                   rd_acc;

    // Requests against a full/empty FIFO are silently dropped here.
    assign wr_acc = i_wr_en & ~o_full;
    assign rd_acc = i_rd_en & ~o_empty;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + COUNT_WIDTH'(1);
        end else if (!wr_acc && rd_acc) begin
            count_next = count - COUNT_WIDTH'(1);
        end
    end

    // Flags come from count_next so they line up with the pointer/data update.
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            o_empty        <= 1'b1;
            o_almost_empty <= 1'b1;
            o_full         <= 1'b0;
            o_almost_full  <= 1'b0;
            o_rd_valid     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count          <= count_next;
            o_empty        <= (count_next == '0);
            o_almost_empty <= (count_next <= AE_THRESH);
            o_full         <= (count_next == DEPTH_C);
            o_almost_full  <= (count_next >= AF_THRESH);
            o_rd_valid     <= rd_acc;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_TYPE   (RAM_TYPE)
    ) u_ram (
        .clk     (i_clk),
        .rst     (i_a_rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (i_wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (o_rd_data)
    );

endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed and paced-random checks of sync_fifo_core, block and distributed variants side by side.
module tb_sync_fifo_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic       b_af, b_full, b_ae, b_empty, b_valid;
    logic [7:0] b_data;
    logic       d_af, d_full, d_ae, d_empty, d_valid;
    logic [7:0] d_data;
    logic       g0, g1, g2, g3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo_core #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .ALMOST_FULL_VAL(2),
                     .ALMOST_EMPTY_VAL(2), .RAM_TYPE("block")) dut_blk (
        .i_clk(clk), .i_a_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_almost_full(b_af), .o_full(b_full), .i_rd_en(rd_en), .o_rd_data(b_data),
        .o_almost_empty(b_ae), .o_empty(b_empty), .o_rd_valid(b_valid));

    sync_fifo_core #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .ALMOST_FULL_VAL(2),
                     .ALMOST_EMPTY_VAL(2), .RAM_TYPE("distributed")) dut_dist (
        .i_clk(clk), .i_a_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_almost_full(d_af), .o_full(d_full), .i_rd_en(rd_en), .o_rd_data(d_data),
        .o_almost_empty(d_ae), .o_empty(d_empty), .o_rd_valid(d_valid));

    random_state_gen #(.STATE_0_MIN_VAL(1), .STATE_0_MAX_VAL(4), .STATE_1_MIN_VAL(1),
                       .STATE_1_MAX_VAL(6), .SEED(32'h1234_5678)) u_g0 (.i_clk(clk), .i_a_rst(rst), .o_state(g0));
    random_state_gen #(.STATE_0_MIN_VAL(1), .STATE_0_MAX_VAL(3), .STATE_1_MIN_VAL(2),
                       .STATE_1_MAX_VAL(8), .SEED(32'hCAFE_F00D)) u_g1 (.i_clk(clk), .i_a_rst(rst), .o_state(g1));
    random_state_gen #(.STATE_0_MIN_VAL(2), .STATE_0_MAX_VAL(5), .STATE_1_MIN_VAL(1),
                       .STATE_1_MAX_VAL(7), .SEED(32'h0BAD_BEEF)) u_g2 (.i_clk(clk), .i_a_rst(rst), .o_state(g2));
    random_state_gen #(.STATE_0_MIN_VAL(1), .STATE_0_MAX_VAL(6), .STATE_1_MIN_VAL(1),
                       .STATE_1_MAX_VAL(5), .SEED(32'h5EED_0001)) u_g3 (.i_clk(clk), .i_a_rst(rst), .o_state(g3));

    // flags packing: {empty, almost_empty, full, almost_full, rd_valid}
    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] wdata;
        logic [4:0] flags;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] wd,
                                input logic [4:0] fl, input logic [7:0] rdat);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wdata = wd; v.flags = fl; v.rdata = rdat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [4:0] e_flags, input logic [7:0] e_data);
        check({tag, ".blk.flags"},  32'({b_empty, b_ae, b_full, b_af, b_valid}), 32'(e_flags));
        check({tag, ".blk.data"},   32'(b_data), 32'(e_data));
        check({tag, ".dist.flags"}, 32'({d_empty, d_ae, d_full, d_af, d_valid}), 32'(e_flags));
        check({tag, ".dist.data"},  32'(d_data), 32'(e_data));
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_data;
        logic [7:0] last_data;
        logic [4:0] drain_fl [4];
        logic       w, r, rd_ok, wr_ok;
        logic [7:0] d;
        int         hi_wr, hi_rd;

        // Reset values appear without any clock edge (first posedge is at t=5).
        #2 rst = 1'b1;
        #1 check_outputs("reset", 5'b11000, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [4:0] fl;
            fl = (i < 2) ? 5'b01000 : (i < 5) ? 5'b00000 : (i < 7) ? 5'b00010 : 5'b00110;
            vecs.push_back(mk(1'b1, 1'b0, 8'(i + 1), fl, 8'h00));
        end
        vecs.push_back(mk(1, 0, 8'hFF, 5'b00110, 8'h00));
        vecs.push_back(mk(0, 1, 8'h00, 5'b00011, 8'h01));
        vecs.push_back(mk(0, 1, 8'h00, 5'b00011, 8'h02));
        vecs.push_back(mk(0, 1, 8'h00, 5'b00001, 8'h03));
        vecs.push_back(mk(0, 1, 8'h00, 5'b00001, 8'h04));
        vecs.push_back(mk(0, 1, 8'h00, 5'b00001, 8'h05));
        vecs.push_back(mk(0, 1, 8'h00, 5'b01001, 8'h06));
        vecs.push_back(mk(0, 1, 8'h00, 5'b01001, 8'h07));
        vecs.push_back(mk(0, 1, 8'h00, 5'b11001, 8'h08));
        vecs.push_back(mk(0, 1, 8'h00, 5'b11000, 8'h08));
        // empty + both: write taken, read dropped
        vecs.push_back(mk(1, 1, 8'h11, 5'b01000, 8'h08));
        vecs.push_back(mk(1, 0, 8'h12, 5'b01000, 8'h08));
        vecs.push_back(mk(1, 0, 8'h13, 5'b00000, 8'h08));
        vecs.push_back(mk(1, 0, 8'h14, 5'b00000, 8'h08));
        vecs.push_back(mk(1, 0, 8'h15, 5'b00000, 8'h08));
        vecs.push_back(mk(1, 0, 8'h16, 5'b00010, 8'h08));
        vecs.push_back(mk(1, 0, 8'h17, 5'b00010, 8'h08));
        vecs.push_back(mk(1, 0, 8'h18, 5'b00110, 8'h08));
        // full + both: oldest word read, 0x99 dropped
        vecs.push_back(mk(1, 1, 8'h99, 5'b00011, 8'h11));
        vecs.push_back(mk(0, 0, 8'h00, 5'b00010, 8'h11));
        vecs.push_back(mk(0, 1, 8'h00, 5'b00011, 8'h12));
        vecs.push_back(mk(0, 1, 8'h00, 5'b00001, 8'h13));
        vecs.push_back(mk(0, 1, 8'h00, 5'b00001, 8'h14));
        vecs.push_back(mk(0, 1, 8'h00, 5'b00001, 8'h15));
        vecs.push_back(mk(0, 1, 8'h00, 5'b01001, 8'h16));
        vecs.push_back(mk(0, 1, 8'h00, 5'b01001, 8'h17));
        vecs.push_back(mk(0, 1, 8'h00, 5'b11001, 8'h18));
        vecs.push_back(mk(0, 1, 8'h00, 5'b11000, 8'h18));

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].wdata);
            check_outputs($sformatf("vec%0d", i), vecs[i].flags, vecs[i].rdata);
        end

        // Steady state at count 4 with simultaneous traffic; 24 writes wrap the pointers 3 times.
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h40 + i));
        check_outputs("steady.fill", 5'b00000, 8'h18);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(8'h44 + i));
            check_outputs($sformatf("steady%0d", i), 5'b00001, 8'(8'h40 + i));
        end
        drain_fl = '{5'b00001, 5'b01001, 5'b01001, 5'b11001};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00);
            check_outputs($sformatf("steady.drain%0d", i), drain_fl[i], 8'(8'h54 + i));
        end

        // Reset in the middle of traffic, between clock edges.
        step(1, 0, 8'h60);
        step(1, 0, 8'h61);
        step(1, 0, 8'h62);
        step(0, 1, 8'h00);
        check_outputs("pre_rst", 5'b01001, 8'h60);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs("mid_rst", 5'b11000, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 1, 8'h00);
        check_outputs("post_rst.rd", 5'b11000, 8'h00);
        step(1, 0, 8'h77);
        check_outputs("post_rst.wr", 5'b01000, 8'h00);
        step(0, 1, 8'h00);
        check_outputs("post_rst.rd2", 5'b11001, 8'h77);

        // Paced random traffic with a queue scoreboard.
        last_data = 8'h77;
        hi_wr = 0;
        hi_rd = 0;
        for (int c = 0; c < 20000; c++) begin
            w = g0 & g1 & ~b_full;
            r = g2 & g3 & ~b_empty;
            d = 8'($urandom);
            rd_ok = r && (q.size() > 0);
            wr_ok = w && (q.size() < 8);
            exp_data = last_data;
            if (rd_ok) begin
                exp_data = q.pop_front();
                hi_rd++;
            end
            if (wr_ok) begin
                q.push_back(d);
                hi_wr++;
            end
            step(w, r, d);
            check_outputs($sformatf("rand%0d", c),
                          {q.size() == 0, q.size() <= 2, q.size() == 8, q.size() >= 6, rd_ok},
                          exp_data);
            last_data = exp_data;
        end
        check("rand.writes_seen", 32'(hi_wr > 1000), 32'd1);
        check("rand.reads_seen",  32'(hi_rd > 1000), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
